// File: rtl/instr_fetch_unit_if.sv
// Bundle between the fetch unit and its neighbours: the Memoria instruction port,
// decode-side valid/ready handshake, and the halt/redirect controls.
interface instr_fetch_unit_if;
    logic [31:0] ReadPC;
    logic [31:0] Instruction;
    logic        halt;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_ready;

    modport master (
        output ReadPC,
        output inst_valid,
        output inst_data,
        output inst_pc,
        input  Instruction,
        input  halt,
        input  redirect_valid,
        input  redirect_pc,
        input  inst_ready
    );

    modport slave (
        input  ReadPC,
        input  inst_valid,
        input  inst_data,
        input  inst_pc,
        output Instruction,
        output halt,
        output redirect_valid,
        output redirect_pc,
        output inst_ready
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// PC generation and prefetch queue in front of the Memoria instruction port;
// issues one word per cycle, captures it a cycle later and hands it to decode.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          QDEPTH    = 4,
    parameter int          MEM_BYTES = 4096
) (
    input logic                clk,
    input logic                rst_n,
    instr_fetch_unit_if.master fetch
);
    localparam int              PW       = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int              CW       = $clog2(QDEPTH) + 1;
    localparam logic [CW-1:0]   DEPTH    = CW'(QDEPTH);
    localparam logic [31:0]     MEM_SIZE = 32'(MEM_BYTES);

    logic [31:0]   read_pc;
    logic [31:0]   inflight_pc;
    logic          inflight;
    logic [31:0]   q_data [QDEPTH];
    logic [31:0]   q_pc   [QDEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
    logic          issue_ok;
    logic          push;
    logic          pop;
    logic [31:0]   next_pc;

    // Issue reserves a queue slot for the word in flight; same-cycle pops are not credited.
    always_comb begin
        issue_ok = !fetch.halt && !fetch.redirect_valid
                   && ((count + CW'(inflight)) < DEPTH);
        push     = inflight && !fetch.redirect_valid;
        pop      = (count != '0) && fetch.inst_ready;
        next_pc  = (read_pc + 32'd4) % MEM_SIZE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            read_pc     <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
        end else if (fetch.redirect_valid) begin
            read_pc  <= fetch.redirect_pc & ~32'd3;
            inflight <= 1'b0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else begin
            inflight <= issue_ok;
            if (issue_ok) begin
                inflight_pc <= read_pc;
                read_pc     <= next_pc;
            end
            if (push) begin
                tail <= tail + PW'(1);
            end
            if (pop) begin
                head <= head + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push) begin
            q_data[tail] <= fetch.Instruction;
            q_pc[tail]   <= inflight_pc;
        end
    end

    always_comb begin
        fetch.ReadPC     = read_pc;
        fetch.inst_valid = (count != '0);
        fetch.inst_data  = '0;
        fetch.inst_pc    = '0;
        if (count != '0) begin
            fetch.inst_data = q_data[head];
            fetch.inst_pc   = q_pc[head];
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a stream-level model (next expected PC,
// quiet windows, hold/stall rules) checked every cycle, plus literal spot checks.
module tb_instr_fetch_unit;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam int          QDEPTH    = 4;
    localparam int          MEM_BYTES = 4096;

    typedef enum {RULE_FREE, RULE_HOLD, RULE_EXACT} rpc_rule_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [31:0] mem [1024];
    int total = 0;
    int bad = 0;

    instr_fetch_unit_if fi();

    instr_fetch_unit #(
        .RESET_PC (RESET_PC),
        .QDEPTH   (QDEPTH),
        .MEM_BYTES(MEM_BYTES)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .fetch(fi)
    );

    always #5 clk = ~clk;

    // Memoria: synchronous read, word appears the cycle after ReadPC.
    always @(posedge clk) fi.Instruction <= mem[fi.ReadPC[11:2]];

    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return (pc + 32'd4) % 32'(MEM_BYTES);
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] pc);
        return mem[pc[11:2]];
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h want %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkAtMost(input string name, input int unsigned actual, input int unsigned limit);
        total++;
        if (actual > limit) begin
            bad++;
            $display("[TB] FAIL %s: got %0d want <= %0d at %0t", name, actual, limit, $time);
        end
    endtask

    task automatic applyStimulus(input logic h, input logic rv, input logic [31:0] rpc, input logic rdy);
        fi.halt           = h;
        fi.redirect_valid = rv;
        fi.redirect_pc    = rpc;
        fi.inst_ready     = rdy;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Model state: next PC decode must see, cycles that must be empty, stall hold, ReadPC rule.
    logic [31:0] exp_pc;
    logic [31:0] rpc_ref;
    logic [31:0] held_pc;
    logic [31:0] held_data;
    logic        hold_pending;
    int          quiet;
    rpc_rule_t   rule;
    int unsigned outstanding;

    // Sampled mid-cycle: outputs reflect the last edge, inputs are those for the next edge.
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_pc       = RESET_PC;
            rpc_ref      = RESET_PC;
            rule         = RULE_EXACT;
            quiet        = 2;
            hold_pending = 1'b0;
        end else begin
            if (quiet > 0) checkOutput("quiet inst_valid", 32'(fi.inst_valid), 32'd0);
            if (fi.inst_valid) begin
                checkOutput("stream inst_pc", fi.inst_pc, exp_pc);
                checkOutput("stream inst_data", fi.inst_data, mem_word(exp_pc));
            end
            if (hold_pending) begin
                checkOutput("stall inst_valid", 32'(fi.inst_valid), 32'd1);
                checkOutput("stall inst_pc", fi.inst_pc, held_pc);
                checkOutput("stall inst_data", fi.inst_data, held_data);
            end
            case (rule)
                RULE_EXACT: checkOutput("ReadPC exact", fi.ReadPC, rpc_ref);
                RULE_HOLD:  checkOutput("ReadPC halted", fi.ReadPC, rpc_ref);
                default:    checkOutput("ReadPC step", fi.ReadPC,
                                        (fi.ReadPC == rpc_ref) ? rpc_ref : pc_plus4(rpc_ref));
            endcase
            outstanding = ((fi.ReadPC + 32'(MEM_BYTES) - exp_pc) % 32'(MEM_BYTES)) / 4;
            checkAtMost("outstanding words", outstanding, QDEPTH);

            if (quiet > 0) quiet--;
            if (fi.redirect_valid) begin
                exp_pc       = fi.redirect_pc & ~32'd3;
                rpc_ref      = exp_pc;
                rule         = RULE_EXACT;
                quiet        = 2;
                hold_pending = 1'b0;
            end else begin
                if (fi.inst_valid && fi.inst_ready) exp_pc = pc_plus4(exp_pc);
                hold_pending = fi.inst_valid && !fi.inst_ready;
                held_pc      = fi.inst_pc;
                held_data    = fi.inst_data;
                rule         = fi.halt ? RULE_HOLD : RULE_FREE;
                rpc_ref      = fi.ReadPC;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] got_pc [8];
        logic [31:0] got_data [8];
        logic [31:0] wrap_pc [4];
        logic [31:0] wrap_data [4];
        logic [31:0] h;
        int n;

        for (int i = 0; i < 1024; i++) mem[i] = 32'hC000_0000 | 32'(i);
        mem[0] = 32'h1111_1111;
        mem[1] = 32'h2222_2222;
        mem[2] = 32'h3333_3333;
        mem[3] = 32'h4444_4444;
        wrap_pc   = '{32'h0000_0FF8, 32'h0000_0FFC, 32'h0000_0000, 32'h0000_0004};
        wrap_data = '{32'hC000_03FE, 32'hC000_03FF, 32'h1111_1111, 32'h2222_2222};

        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        tick(3);
        checkOutput("reset ReadPC", fi.ReadPC, RESET_PC);
        checkOutput("reset inst_valid", 32'(fi.inst_valid), 32'd0);
        checkOutput("reset inst_pc", fi.inst_pc, 32'd0);
        checkOutput("reset inst_data", fi.inst_data, 32'd0);

        // Start-up stream with decode always ready.
        rst_n = 1'b1;
        tick(1);
        checkOutput("t1 e1 ReadPC", fi.ReadPC, 32'd4);
        checkOutput("t1 e1 inst_valid", 32'(fi.inst_valid), 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick(1);
            checkOutput("t1 inst_valid", 32'(fi.inst_valid), 32'd1);
            checkOutput("t1 inst_pc", fi.inst_pc, 32'(4 * k));
            checkOutput("t1 inst_data", fi.inst_data, mem_word(32'(4 * k)));
            checkOutput("t1 ReadPC", fi.ReadPC, 32'(4 * k + 8));
        end
        checkOutput("t1 literal data", fi.inst_data, 32'h4444_4444);

        // Decode stalled from reset: queue fills, ReadPC freezes, then drains in order.
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        tick(2);
        rst_n = 1'b1;
        tick(8);
        checkOutput("t2 ReadPC frozen", fi.ReadPC, 32'd16);
        checkOutput("t2 head pc", fi.inst_pc, 32'd0);
        checkOutput("t2 head data", fi.inst_data, 32'h1111_1111);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        n = 0;
        for (int c = 0; c < 20 && n < 5; c++) begin
            if (fi.inst_valid) begin
                got_pc[n] = fi.inst_pc;
                n++;
            end
            tick(1);
        end
        checkOutput("t2 delivered count", 32'(n), 32'd5);
        for (int i = 0; i < n; i++) checkOutput("t2 drain pc", got_pc[i], 32'(4 * i));

        // Redirect with two entries queued and one word in flight.
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        tick(2);
        rst_n = 1'b1;
        tick(3);
        checkOutput("t3 pre ReadPC", fi.ReadPC, 32'd12);
        applyStimulus(1'b0, 1'b1, 32'h0000_0102, 1'b0);
        tick(1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("t3 redirect ReadPC", fi.ReadPC, 32'h0000_0100);
        checkOutput("t3 gap1 inst_valid", 32'(fi.inst_valid), 32'd0);
        tick(1);
        checkOutput("t3 gap2 inst_valid", 32'(fi.inst_valid), 32'd0);
        checkOutput("t3 issue ReadPC", fi.ReadPC, 32'h0000_0104);
        tick(1);
        checkOutput("t3 first inst_valid", 32'(fi.inst_valid), 32'd1);
        checkOutput("t3 first inst_pc", fi.inst_pc, 32'h0000_0100);
        checkOutput("t3 first inst_data", fi.inst_data, 32'hC000_0040);

        // Halt for five edges mid-stream.
        tick(4);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        h = fi.ReadPC;
        checkOutput("t4 halt ReadPC", h, 32'h0000_0118);
        tick(1);
        checkOutput("t4 inflight delivered valid", 32'(fi.inst_valid), 32'd1);
        checkOutput("t4 inflight delivered pc", fi.inst_pc, h - 32'd4);
        for (int k = 0; k < 4; k++) begin
            tick(1);
            checkOutput("t4 ReadPC held", fi.ReadPC, h);
            checkOutput("t4 drained", 32'(fi.inst_valid), 32'd0);
        end
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        tick(1);
        checkOutput("t4 resume ReadPC", fi.ReadPC, h + 32'd4);
        tick(1);
        checkOutput("t4 resume valid", 32'(fi.inst_valid), 32'd1);
        checkOutput("t4 resume pc", fi.inst_pc, h);

        // Redirect near the top of memory: fetch wraps to 0.
        applyStimulus(1'b0, 1'b1, 32'h0000_0FF8, 1'b1);
        tick(1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        n = 0;
        for (int c = 0; c < 20 && n < 4; c++) begin
            if (fi.inst_valid) begin
                got_pc[n]   = fi.inst_pc;
                got_data[n] = fi.inst_data;
                n++;
            end
            tick(1);
        end
        checkOutput("t5 delivered count", 32'(n), 32'd4);
        for (int i = 0; i < n; i++) begin
            checkOutput("t5 wrap pc", got_pc[i], wrap_pc[i]);
            checkOutput("t5 wrap data", got_data[i], wrap_data[i]);
        end

        // Fill the queue, then pulse reset between edges.
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        tick(6);
        checkOutput("t6 full valid", 32'(fi.inst_valid), 32'd1);
        checkOutput("t6 full ReadPC", fi.ReadPC, (fi.inst_pc + 32'd16) % 32'(MEM_BYTES));
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t6 async inst_valid", 32'(fi.inst_valid), 32'd0);
        checkOutput("t6 async ReadPC", fi.ReadPC, RESET_PC);
        checkOutput("t6 async inst_pc", fi.inst_pc, 32'd0);
        checkOutput("t6 async inst_data", fi.inst_data, 32'd0);
        tick(1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        rst_n = 1'b1;
        tick(1);
        checkOutput("t6 restart e1 valid", 32'(fi.inst_valid), 32'd0);
        checkOutput("t6 restart e1 ReadPC", fi.ReadPC, 32'd4);
        tick(1);
        checkOutput("t6 restart valid", 32'(fi.inst_valid), 32'd1);
        checkOutput("t6 restart pc", fi.inst_pc, 32'd0);
        checkOutput("t6 restart data", fi.inst_data, 32'h1111_1111);
        tick(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- PC-generation and prefetch stage directly upstream of the Memoria instruction port.
- Drives ReadPC, captures Instruction one cycle later, and buffers fetched words with their PCs in a small FIFO.
- Presents the buffered words to decode over a valid/ready handshake.
- Supports redirect (branch/jump) with full flush of queued and in-flight fetches, and a halt input that stops new fetches.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- QDEPTH, 4, prefetch queue entries (power of two, >=2).
- MEM_BYTES, 4096, instruction space size; PC wraps modulo MEM_BYTES (1024 words).

Ports:
- clk  in  1  rising-edge clock, shared with Memoria
- rst_n  in  1  asynchronous active-low reset
- ReadPC  out  32  byte address of the word fetched this cycle; Memoria uses ReadPC[11:2]
- Instruction  in  32  word returned by Memoria, valid the cycle after ReadPC was presented
- halt  in  1  when high, no new fetch is issued
- redirect_valid  in  1  one-cycle pulse: restart fetch at redirect_pc
- redirect_pc  in  32  new PC; bits [1:0] forced to 0
- inst_valid  out  1  queue head valid toward decode
- inst_data  out  32  queue head instruction
- inst_pc  out  32  byte PC of inst_data
- inst_ready  in  1  decode accepts head when inst_valid && inst_ready

Behaviour:
- Reset (async, rst_n=0):
  - ReadPC=RESET_PC, queue empty, in-flight flag clear.
  - inst_valid=0, inst_data=0, inst_pc=0.
  - Reset applied mid-operation discards everything immediately, with no edge needed.
- Issue condition per cycle: issue_ok = !halt && !redirect_valid && (occupancy + inflight < QDEPTH). Pops in the same cycle are not credited, so the check is conservative.
- Issue at edge: if issue_ok, inflight<=1, inflight_pc<=ReadPC, and ReadPC<=(ReadPC+4) mod MEM_BYTES. Otherwise ReadPC holds and inflight<=0.
- Capture at edge: if inflight && !redirect_valid, push {inflight_pc, Instruction} to the tail. Fetch-to-queue latency is 1 cycle; fetch-to-inst_valid is 2 edges after issue.
- Pop at edge: if inst_valid && inst_ready, advance head.
  - Push and pop may occur on the same edge; occupancy is then unchanged.
  - A push into an empty queue is visible on the next cycle (no bypass).
- Redirect at edge (highest priority):
  - ReadPC<=redirect_pc & ~3, queue emptied, inflight<=0.
  - Any response arriving in the next cycle is ignored.
  - inst_valid=0 the following cycle. A handshake completed in the redirect cycle counts as consumed.
  - First post-redirect instruction: inst_valid rises 2 edges after the redirect edge (issue edge, then capture edge).
- Halt:
  - Stops issue only; an in-flight word is still captured and the queue still drains to decode.
  - Deasserting halt resumes from the held ReadPC.
- Full queue: no issue; ReadPC holds and no word is dropped or duplicated.
- Wrap: a PC of MEM_BYTES-4 is followed by 0.
- inst_data and inst_pc are stable while inst_valid && !inst_ready (no redirect).
- Occupancy counter width is clog2(QDEPTH)+1; pointers wrap modulo QDEPTH.

Test Plan:
- Reset release, memory words 0..3 = 11111111, 22222222, 33333333, 44444444, inst_ready=1 -> ReadPC 0,4,8,... each cycle; inst_valid rises at edge 2; inst_pc/data sequence 0/11111111, 4/22222222, 8/33333333, 12/44444444 on consecutive cycles.
- inst_ready=0 from start (QDEPTH=4) -> exactly 4 entries queued, ReadPC frozen at 16, head holds 0/11111111; raise inst_ready -> pcs 0,4,8,12,16 delivered in order, none lost or duplicated.
- Redirect to 32'h0000_0102 while the queue holds 2 entries -> ReadPC=0x100 next cycle, inst_valid=0 for 2 cycles, then inst_pc=0x100 with mem[64]; the stale in-flight word is never output.
- halt=1 for 5 cycles mid-stream -> ReadPC constant; the in-flight word is delivered; after deassertion, fetch continues at the next sequential PC.
- Redirect to 0xFF8 -> pcs 0xFF8, 0xFFC, 0x000, 0x004 (wrap).
- rst_n pulsed low asynchronously between edges with a full queue -> inst_valid=0 and ReadPC=RESET_PC immediately; normal start-up sequence after release.
